// File: rtl/yarvi_commit_pkg.sv
// Shared definitions for the yarvi commit stage: trap causes, FSM state
// encodings, the trap-write record and a small cause-selection helper.
package yarvi_commit_pkg;

   // Trap causes written into mcause
   localparam logic [31:0] CAUSE_LD_MISALIGNED = 32'd4;
   localparam logic [31:0] CAUSE_ST_MISALIGNED = 32'd6;
   localparam logic [31:0] CAUSE_M_TIMER       = 32'h8000_0007;

   // Width of the post-redirect squash counter (FLUSH_CYCLES is 1..15)
   localparam int FLUSH_CNT_W = 4;

   // Commit FSM: RUN accepts ME results, FLUSH drops wrong-path results
   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } commit_state_e;

   // One trap-write request towards the trap CSR block
   typedef struct packed {
      logic        we;
      logic [31:0] epc;
      logic [31:0] cause;
      logic [31:0] val;
   } trap_wr_t;

   // Misaligned cause depends only on whether the access was a store
   function automatic logic [31:0] misaligned_cause(input logic is_store);
      logic [31:0] cause;
      if (is_store) begin
         cause = CAUSE_ST_MISALIGNED;
      end else begin
         cause = CAUSE_LD_MISALIGNED;
      end
      return cause;
   endfunction

endpackage

// File: rtl/yarvi_commit_if.sv
// Bundle of the ME-stage result, CSR inputs and commit-stage outputs.
// The pipeline side (master) drives ME/CSR inputs; the commit stage (slave)
// drives register-file, redirect and CSR outputs.
interface yarvi_commit_if;

   // ME stage result and events
   logic        me_valid;
   logic [31:0] me_pc;
   logic [4:0]  me_wb_rd;
   logic [31:0] me_wb_val;
   logic        me_is_store;
   logic        me_exc_misaligned;
   logic [31:0] me_exc_mtval;
   logic        me_load_hit_store;
   logic        me_timer_interrupt;

   // CSR state consumed by the commit stage
   logic        csr_mie;
   logic [31:0] csr_mtvec;

   // Commit stage results
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        restart;
   logic [31:0] restart_pc;
   logic [31:0] mepc;
   logic [31:0] mcause;
   logic [31:0] mtval;
   logic [63:0] minstret;

   modport master (
      output me_valid, me_pc, me_wb_rd, me_wb_val, me_is_store,
             me_exc_misaligned, me_exc_mtval, me_load_hit_store,
             me_timer_interrupt, csr_mie, csr_mtvec,
      input  rf_we, rf_waddr, rf_wdata, restart, restart_pc,
             mepc, mcause, mtval, minstret
   );

   modport slave (
      input  me_valid, me_pc, me_wb_rd, me_wb_val, me_is_store,
             me_exc_misaligned, me_exc_mtval, me_load_hit_store,
             me_timer_interrupt, csr_mie, csr_mtvec,
      output rf_we, rf_waddr, rf_wdata, restart, restart_pc,
             mepc, mcause, mtval, minstret
   );

endinterface

// File: rtl/yarvi_trap_csr.sv
// Trap CSR holder: mepc/mcause/mtval updated together through a single
// trap-write port and held until the next trap.
module yarvi_trap_csr
   import yarvi_commit_pkg::*;
(
   input  logic        clock,
   input  logic        reset,      // asynchronous, active-low
   input  trap_wr_t    i_trap,
   output logic [31:0] o_mepc,
   output logic [31:0] o_mcause,
   output logic [31:0] o_mtval
);

   logic [31:0] r_mepc;
   logic [31:0] r_mcause;
   logic [31:0] r_mtval;

   // Capture all three trap CSRs atomically on a trap write, hold otherwise
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_mepc   <= 32'd0;
         r_mcause <= 32'd0;
         r_mtval  <= 32'd0;
      end else if (i_trap.we) begin
         r_mepc   <= i_trap.epc;
         r_mcause <= i_trap.cause;
         r_mtval  <= i_trap.val;
      end else begin
         r_mepc   <= r_mepc;
         r_mcause <= r_mcause;
         r_mtval  <= r_mtval;
      end
   end

   assign o_mepc   = r_mepc;
   assign o_mcause = r_mcause;
   assign o_mtval  = r_mtval;

endmodule

// File: rtl/yarvi_commit.sv
// Writeback/commit stage behind the load-store unit. Retires ME results into
// the register file, converts misaligned accesses and timer interrupts into
// traps, converts load-hit-store into a replay, and issues the single
// redirect to fetch followed by a fixed squash window for wrong-path results.
module yarvi_commit
   import yarvi_commit_pkg::*;
#(
   parameter int          FLUSH_CYCLES = 2,              // 1..15
   parameter logic [31:0] RESET_PC     = 32'h8000_0000
)
(
   input  logic          clock,
   input  logic          reset,     // asynchronous, active-low
   yarvi_commit_if.slave bus
);

   // Counter value loaded when the squash window opens
   localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

   commit_state_e          r_state;
   logic [FLUSH_CNT_W-1:0] r_flush_cnt;
   logic                   r_rf_we;
   logic [4:0]             r_rf_waddr;
   logic [31:0]            r_rf_wdata;
   logic                   r_restart;
   logic [31:0]            r_restart_pc;
   logic [63:0]            r_minstret;

   logic                   w_run;
   logic                   w_take_mis;
   logic                   w_take_lhs;
   logic                   w_take_irq;
   logic                   w_retire;
   logic                   w_redirect;
   trap_wr_t               w_trap;
   logic [31:0]            w_mepc;
   logic [31:0]            w_mcause;
   logic [31:0]            w_mtval;

   // Priority decode of the ME events; nothing is accepted outside RUN
   always_comb begin
      w_run      = (r_state == ST_RUN);
      w_take_mis = 1'b0;
      w_take_lhs = 1'b0;
      w_take_irq = 1'b0;
      w_retire   = 1'b0;
      if (!w_run) begin
         w_take_mis = 1'b0;
      end else if (bus.me_exc_misaligned) begin
         w_take_mis = 1'b1;
      end else if (bus.me_load_hit_store) begin
         w_take_lhs = 1'b1;
      end else if (bus.me_valid && bus.me_timer_interrupt && bus.csr_mie) begin
         // Interrupt is taken in front of this instruction, so it does not retire
         w_take_irq = 1'b1;
      end else if (bus.me_valid) begin
         w_retire = 1'b1;
      end else begin
         w_retire = 1'b0;
      end
      w_redirect = w_take_mis | w_take_lhs | w_take_irq;
   end

   // Build the trap-write request for the CSR block (replays leave CSRs alone)
   always_comb begin
      w_trap = '0;
      if (w_take_mis) begin
         w_trap.we    = 1'b1;
         w_trap.epc   = bus.me_pc;
         w_trap.cause = misaligned_cause(bus.me_is_store);
         w_trap.val   = bus.me_exc_mtval;
      end else if (w_take_irq) begin
         w_trap.we    = 1'b1;
         w_trap.epc   = bus.me_pc;
         w_trap.cause = CAUSE_M_TIMER;
         w_trap.val   = 32'd0;
      end else begin
         w_trap.we    = 1'b0;
      end
   end

   yarvi_trap_csr u_trap_csr (
      .clock    (clock),
      .reset    (reset),
      .i_trap   (w_trap),
      .o_mepc   (w_mepc),
      .o_mcause (w_mcause),
      .o_mtval  (w_mtval)
   );

   // Commit FSM with registered writeback, redirect and retire counter
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_RUN;
         r_flush_cnt  <= '0;
         r_rf_we      <= 1'b0;
         r_rf_waddr   <= 5'd0;
         r_rf_wdata   <= 32'd0;
         r_restart    <= 1'b0;
         r_restart_pc <= RESET_PC;
         r_minstret   <= 64'd0;
      end else begin
         // Redirect pulse is one cycle; FLUSH blocks a second one right after
         r_restart <= w_redirect;
         r_rf_we   <= w_retire && (bus.me_wb_rd != 5'd0);

         if (w_retire) begin
            r_rf_waddr <= bus.me_wb_rd;
            r_rf_wdata <= bus.me_wb_val;
            r_minstret <= r_minstret + 64'd1;   // wraps naturally at 2^64
         end else begin
            r_rf_waddr <= r_rf_waddr;
            r_rf_wdata <= r_rf_wdata;
            r_minstret <= r_minstret;
         end

         if (w_take_mis || w_take_irq) begin
            r_restart_pc <= bus.csr_mtvec;
         end else if (w_take_lhs) begin
            r_restart_pc <= bus.me_pc;          // replay the load
         end else begin
            r_restart_pc <= r_restart_pc;
         end

         case (r_state)
            ST_RUN: begin
               if (w_redirect) begin
                  r_state     <= ST_FLUSH;
                  r_flush_cnt <= FLUSH_LOAD;
               end else begin
                  r_state     <= ST_RUN;
                  r_flush_cnt <= r_flush_cnt;
               end
            end
            ST_FLUSH: begin
               // The cycle with counter 0 is the last squashed one
               if (r_flush_cnt == '0) begin
                  r_state     <= ST_RUN;
                  r_flush_cnt <= r_flush_cnt;
               end else begin
                  r_state     <= ST_FLUSH;
                  r_flush_cnt <= r_flush_cnt - 1'b1;
               end
            end
            default: begin
               r_state     <= ST_RUN;
               r_flush_cnt <= '0;
            end
         endcase
      end
   end

   assign bus.rf_we      = r_rf_we;
   assign bus.rf_waddr   = r_rf_waddr;
   assign bus.rf_wdata   = r_rf_wdata;
   assign bus.restart    = r_restart;
   assign bus.restart_pc = r_restart_pc;
   assign bus.mepc       = w_mepc;
   assign bus.mcause     = w_mcause;
   assign bus.mtval      = w_mtval;
   assign bus.minstret   = r_minstret;

endmodule

// File: tb/tb_yarvi_commit.sv
// Directed self-checking bench for yarvi_commit: retire, traps, replay,
// squash window, reset during squash and minstret wrap.
module tb_yarvi_commit;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   yarvi_commit_if bus_if();

   yarvi_commit #(
      .FLUSH_CYCLES (2),
      .RESET_PC     (32'h8000_0000)
   ) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus_if)
   );

   // 10 time-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      bus_if.me_valid           = 1'b0;
      bus_if.me_pc              = 32'd0;
      bus_if.me_wb_rd           = 5'd0;
      bus_if.me_wb_val          = 32'd0;
      bus_if.me_is_store        = 1'b0;
      bus_if.me_exc_misaligned  = 1'b0;
      bus_if.me_exc_mtval       = 32'd0;
      bus_if.me_load_hit_store  = 1'b0;
      bus_if.me_timer_interrupt = 1'b0;
      bus_if.csr_mie            = 1'b0;
      bus_if.csr_mtvec          = 32'h8000_0040;
   endtask

   // One clock: inputs set before, outputs sampled at the following negedge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      step();
      step();
      checks++; if (bus_if.rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%0h exp=0", bus_if.rf_we); end
      checks++; if (bus_if.rf_waddr !== 5'd0) begin failures++; $display("FAIL reset_rf_waddr got=%0h exp=0", bus_if.rf_waddr); end
      checks++; if (bus_if.rf_wdata !== 32'd0) begin failures++; $display("FAIL reset_rf_wdata got=%0h exp=0", bus_if.rf_wdata); end
      checks++; if (bus_if.restart !== 1'b0) begin failures++; $display("FAIL reset_restart got=%0h exp=0", bus_if.restart); end
      checks++; if (bus_if.restart_pc !== 32'h8000_0000) begin failures++; $display("FAIL reset_restart_pc got=%0h exp=80000000", bus_if.restart_pc); end
      checks++; if (bus_if.mepc !== 32'd0) begin failures++; $display("FAIL reset_mepc got=%0h exp=0", bus_if.mepc); end
      checks++; if (bus_if.mcause !== 32'd0) begin failures++; $display("FAIL reset_mcause got=%0h exp=0", bus_if.mcause); end
      checks++; if (bus_if.mtval !== 32'd0) begin failures++; $display("FAIL reset_mtval got=%0h exp=0", bus_if.mtval); end
      checks++; if (bus_if.minstret !== 64'd0) begin failures++; $display("FAIL reset_minstret got=%0h exp=0", bus_if.minstret); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_retire();
      bus_if.me_valid  = 1'b1;
      bus_if.me_pc     = 32'h8000_0000;
      bus_if.me_wb_rd  = 5'd5;
      bus_if.me_wb_val = 32'h1234;
      step();
      checks++; if (bus_if.rf_we !== 1'b1) begin failures++; $display("FAIL retire_we got=%0h exp=1", bus_if.rf_we); end
      checks++; if (bus_if.rf_waddr !== 5'd5) begin failures++; $display("FAIL retire_waddr got=%0h exp=5", bus_if.rf_waddr); end
      checks++; if (bus_if.rf_wdata !== 32'h1234) begin failures++; $display("FAIL retire_wdata got=%0h exp=1234", bus_if.rf_wdata); end
      checks++; if (bus_if.minstret !== 64'd1) begin failures++; $display("FAIL retire_minstret1 got=%0h exp=1", bus_if.minstret); end
      bus_if.me_pc    = 32'h8000_0004;
      bus_if.me_wb_rd = 5'd0;
      step();
      checks++; if (bus_if.rf_we !== 1'b0) begin failures++; $display("FAIL retire_rd0_we got=%0h exp=0", bus_if.rf_we); end
      checks++; if (bus_if.minstret !== 64'd2) begin failures++; $display("FAIL retire_minstret2 got=%0h exp=2", bus_if.minstret); end
      idle_inputs();
      step();
      checks++; if (bus_if.rf_we !== 1'b0) begin failures++; $display("FAIL retire_idle_we got=%0h exp=0", bus_if.rf_we); end
      checks++; if (bus_if.minstret !== 64'd2) begin failures++; $display("FAIL retire_idle_minstret got=%0h exp=2", bus_if.minstret); end
   endtask

   task automatic test_misaligned();
      idle_inputs();
      bus_if.me_exc_misaligned = 1'b1;
      bus_if.me_is_store       = 1'b1;
      bus_if.me_pc             = 32'h8000_0100;
      bus_if.me_exc_mtval      = 32'h8000_0203;
      bus_if.csr_mtvec         = 32'h8000_0040;
      step();
      checks++; if (bus_if.restart !== 1'b1) begin failures++; $display("FAIL mis_restart got=%0h exp=1", bus_if.restart); end
      checks++; if (bus_if.restart_pc !== 32'h8000_0040) begin failures++; $display("FAIL mis_restart_pc got=%0h exp=80000040", bus_if.restart_pc); end
      checks++; if (bus_if.mepc !== 32'h8000_0100) begin failures++; $display("FAIL mis_mepc got=%0h exp=80000100", bus_if.mepc); end
      checks++; if (bus_if.mcause !== 32'd6) begin failures++; $display("FAIL mis_mcause got=%0h exp=6", bus_if.mcause); end
      checks++; if (bus_if.mtval !== 32'h8000_0203) begin failures++; $display("FAIL mis_mtval got=%0h exp=80000203", bus_if.mtval); end
      checks++; if (bus_if.rf_we !== 1'b0) begin failures++; $display("FAIL mis_rf_we got=%0h exp=0", bus_if.rf_we); end
      idle_inputs();
      bus_if.me_valid  = 1'b1;
      bus_if.me_wb_rd  = 5'd3;
      bus_if.me_wb_val = 32'h55;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (bus_if.rf_we !== 1'b0) begin failures++; $display("FAIL mis_flush_we[%0d] got=%0h exp=0", i, bus_if.rf_we); end
         checks++; if (bus_if.restart !== 1'b0) begin failures++; $display("FAIL mis_flush_restart[%0d] got=%0h exp=0", i, bus_if.restart); end
         checks++; if (bus_if.minstret !== 64'd2) begin failures++; $display("FAIL mis_flush_minstret[%0d] got=%0h exp=2", i, bus_if.minstret); end
      end
      step();
      checks++; if (bus_if.rf_we !== 1'b1) begin failures++; $display("FAIL mis_after_we got=%0h exp=1", bus_if.rf_we); end
      checks++; if (bus_if.rf_wdata !== 32'h55) begin failures++; $display("FAIL mis_after_wdata got=%0h exp=55", bus_if.rf_wdata); end
      checks++; if (bus_if.minstret !== 64'd3) begin failures++; $display("FAIL mis_after_minstret got=%0h exp=3", bus_if.minstret); end
      idle_inputs();
      step();
   endtask

   task automatic test_load_hit_store();
      idle_inputs();
      bus_if.me_load_hit_store = 1'b1;
      bus_if.me_pc             = 32'h8000_0200;
      step();
      checks++; if (bus_if.restart !== 1'b1) begin failures++; $display("FAIL lhs_restart got=%0h exp=1", bus_if.restart); end
      checks++; if (bus_if.restart_pc !== 32'h8000_0200) begin failures++; $display("FAIL lhs_restart_pc got=%0h exp=80000200", bus_if.restart_pc); end
      checks++; if (bus_if.mcause !== 32'd6) begin failures++; $display("FAIL lhs_mcause got=%0h exp=6", bus_if.mcause); end
      checks++; if (bus_if.mepc !== 32'h8000_0100) begin failures++; $display("FAIL lhs_mepc got=%0h exp=80000100", bus_if.mepc); end
      checks++; if (bus_if.minstret !== 64'd3) begin failures++; $display("FAIL lhs_minstret got=%0h exp=3", bus_if.minstret); end
      checks++; if (bus_if.rf_we !== 1'b0) begin failures++; $display("FAIL lhs_rf_we got=%0h exp=0", bus_if.rf_we); end
      idle_inputs();
      step();
      checks++; if (bus_if.restart !== 1'b0) begin failures++; $display("FAIL lhs_pulse_width got=%0h exp=0", bus_if.restart); end
      step();
      step();
   endtask

   task automatic test_timer();
      idle_inputs();
      bus_if.me_timer_interrupt = 1'b1;
      bus_if.csr_mie            = 1'b0;
      bus_if.me_valid           = 1'b1;
      bus_if.me_wb_rd           = 5'd9;
      for (int i = 0; i < 3; i++) begin
         bus_if.me_pc     = 32'h8000_0300 + 32'(i * 4);
         bus_if.me_wb_val = 32'(i + 100);
         step();
         checks++; if (bus_if.rf_we !== 1'b1) begin failures++; $display("FAIL tmr_masked_we[%0d] got=%0h exp=1", i, bus_if.rf_we); end
         checks++; if (bus_if.restart !== 1'b0) begin failures++; $display("FAIL tmr_masked_restart[%0d] got=%0h exp=0", i, bus_if.restart); end
      end
      checks++; if (bus_if.minstret !== 64'd6) begin failures++; $display("FAIL tmr_masked_minstret got=%0h exp=6", bus_if.minstret); end
      bus_if.csr_mie = 1'b1;
      bus_if.me_pc   = 32'h8000_0310;
      step();
      checks++; if (bus_if.restart !== 1'b1) begin failures++; $display("FAIL tmr_restart got=%0h exp=1", bus_if.restart); end
      checks++; if (bus_if.restart_pc !== 32'h8000_0040) begin failures++; $display("FAIL tmr_restart_pc got=%0h exp=80000040", bus_if.restart_pc); end
      checks++; if (bus_if.mcause !== 32'h8000_0007) begin failures++; $display("FAIL tmr_mcause got=%0h exp=80000007", bus_if.mcause); end
      checks++; if (bus_if.mepc !== 32'h8000_0310) begin failures++; $display("FAIL tmr_mepc got=%0h exp=80000310", bus_if.mepc); end
      checks++; if (bus_if.mtval !== 32'd0) begin failures++; $display("FAIL tmr_mtval got=%0h exp=0", bus_if.mtval); end
      checks++; if (bus_if.rf_we !== 1'b0) begin failures++; $display("FAIL tmr_rf_we got=%0h exp=0", bus_if.rf_we); end
      checks++; if (bus_if.minstret !== 64'd6) begin failures++; $display("FAIL tmr_minstret got=%0h exp=6", bus_if.minstret); end
      // Level stays pending: squashed for two cycles, then taken again
      bus_if.me_pc = 32'h8000_0314;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (bus_if.restart !== 1'b0) begin failures++; $display("FAIL tmr_flush_restart[%0d] got=%0h exp=0", i, bus_if.restart); end
         checks++; if (bus_if.rf_we !== 1'b0) begin failures++; $display("FAIL tmr_flush_we[%0d] got=%0h exp=0", i, bus_if.rf_we); end
      end
      step();
      checks++; if (bus_if.restart !== 1'b1) begin failures++; $display("FAIL tmr_retake_restart got=%0h exp=1", bus_if.restart); end
      checks++; if (bus_if.mepc !== 32'h8000_0314) begin failures++; $display("FAIL tmr_retake_mepc got=%0h exp=80000314", bus_if.mepc); end
      checks++; if (bus_if.minstret !== 64'd6) begin failures++; $display("FAIL tmr_retake_minstret got=%0h exp=6", bus_if.minstret); end
      idle_inputs();
      step();
      step();
      step();
   endtask

   task automatic test_priority();
      int pulses;
      pulses = 0;
      idle_inputs();
      bus_if.me_exc_misaligned  = 1'b1;
      bus_if.me_is_store        = 1'b0;
      bus_if.me_timer_interrupt = 1'b1;
      bus_if.csr_mie            = 1'b1;
      bus_if.me_pc              = 32'h8000_0400;
      bus_if.me_exc_mtval       = 32'h8000_0401;
      step();
      if (bus_if.restart === 1'b1) pulses++;
      checks++; if (bus_if.mcause !== 32'd4) begin failures++; $display("FAIL prio_mcause got=%0h exp=4", bus_if.mcause); end
      checks++; if (bus_if.mepc !== 32'h8000_0400) begin failures++; $display("FAIL prio_mepc got=%0h exp=80000400", bus_if.mepc); end
      checks++; if (bus_if.mtval !== 32'h8000_0401) begin failures++; $display("FAIL prio_mtval got=%0h exp=80000401", bus_if.mtval); end
      // Second misaligned event arrives inside the squash window
      idle_inputs();
      bus_if.me_exc_misaligned = 1'b1;
      bus_if.me_is_store       = 1'b1;
      bus_if.me_pc             = 32'h8000_0500;
      bus_if.me_exc_mtval      = 32'h8000_0503;
      for (int i = 0; i < 2; i++) begin
         step();
         if (bus_if.restart === 1'b1) pulses++;
         checks++; if (bus_if.mcause !== 32'd4) begin failures++; $display("FAIL prio_flush_mcause[%0d] got=%0h exp=4", i, bus_if.mcause); end
      end
      idle_inputs();
      step();
      if (bus_if.restart === 1'b1) pulses++;
      checks++; if (pulses !== 1) begin failures++; $display("FAIL prio_pulses got=%0d exp=1", pulses); end
      checks++; if (bus_if.mepc !== 32'h8000_0400) begin failures++; $display("FAIL prio_final_mepc got=%0h exp=80000400", bus_if.mepc); end
   endtask

   task automatic test_reset_in_flush();
      idle_inputs();
      bus_if.me_load_hit_store = 1'b1;
      bus_if.me_pc             = 32'h8000_0600;
      step();
      idle_inputs();
      step();
      rst_n = 1'b0;
      #1;
      checks++; if (bus_if.restart !== 1'b0) begin failures++; $display("FAIL rstfl_restart got=%0h exp=0", bus_if.restart); end
      checks++; if (bus_if.restart_pc !== 32'h8000_0000) begin failures++; $display("FAIL rstfl_restart_pc got=%0h exp=80000000", bus_if.restart_pc); end
      checks++; if (bus_if.mcause !== 32'd0) begin failures++; $display("FAIL rstfl_mcause got=%0h exp=0", bus_if.mcause); end
      checks++; if (bus_if.mepc !== 32'd0) begin failures++; $display("FAIL rstfl_mepc got=%0h exp=0", bus_if.mepc); end
      checks++; if (bus_if.minstret !== 64'd0) begin failures++; $display("FAIL rstfl_minstret got=%0h exp=0", bus_if.minstret); end
      @(negedge clk);
      rst_n = 1'b1;
      bus_if.me_valid  = 1'b1;
      bus_if.me_pc     = 32'h8000_0000;
      bus_if.me_wb_rd  = 5'd7;
      bus_if.me_wb_val = 32'hABC;
      step();
      checks++; if (bus_if.rf_we !== 1'b1) begin failures++; $display("FAIL rstfl_retire_we got=%0h exp=1", bus_if.rf_we); end
      checks++; if (bus_if.rf_waddr !== 5'd7) begin failures++; $display("FAIL rstfl_retire_waddr got=%0h exp=7", bus_if.rf_waddr); end
      checks++; if (bus_if.minstret !== 64'd1) begin failures++; $display("FAIL rstfl_retire_minstret got=%0h exp=1", bus_if.minstret); end
      checks++; if (bus_if.restart !== 1'b0) begin failures++; $display("FAIL rstfl_no_restart got=%0h exp=0", bus_if.restart); end
      idle_inputs();
      step();
   endtask

   task automatic test_minstret_wrap();
      idle_inputs();
      force dut.r_minstret = 64'hFFFF_FFFF_FFFF_FFFE;
      #1;
      release dut.r_minstret;
      bus_if.me_valid  = 1'b1;
      bus_if.me_wb_rd  = 5'd1;
      bus_if.me_wb_val = 32'h1;
      step();
      checks++; if (bus_if.minstret !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL wrap_max got=%0h exp=ffffffffffffffff", bus_if.minstret); end
      step();
      checks++; if (bus_if.minstret !== 64'd0) begin failures++; $display("FAIL wrap_zero got=%0h exp=0", bus_if.minstret); end
      checks++; if (bus_if.rf_we !== 1'b1) begin failures++; $display("FAIL wrap_we got=%0h exp=1", bus_if.rf_we); end
      step();
      checks++; if (bus_if.minstret !== 64'd1) begin failures++; $display("FAIL wrap_one got=%0h exp=1", bus_if.minstret); end
      idle_inputs();
      step();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_retire();
      test_misaligned();
      test_load_hit_store();
      test_timer();
      test_priority();
      test_reset_in_flush();
      test_minstret_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
